fc_sequencer: RTL and testbench

//  Drives one fully-connected layer pass over N_OUT output neurons using the single-neuron FC datapath.
//  - Per neuron: addresses the weight/bias memory, pulses the FC start, waits for FC finished.
//  - Emits each neuron's 32-bit result on a write port and tracks the winning class.
//  - Sits between the top-level inference controller and the FC datapath plus weight ROM.

---
 rtl/fc_seq_pkg.sv | 16 +
 rtl/fc_seq_argmax.sv | 38 +++
 rtl/fc_sequencer.sv | 149 ++++++++++++++
 tb/tb_fc_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_seq_pkg.sv
// Shared types for the FC layer sequencer: FSM state encoding and result width.
package fc_seq_pkg;

  localparam int unsigned RES_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/fc_seq_argmax.sv
// Running signed maximum over the neuron results of one pass.
// Instantiated by fc_sequencer only when FC_SEQ_ARGMAX_EN is defined.
module fc_seq_argmax
  import fc_seq_pkg::*;
#(
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             update,
  input  logic [IDX_W-1:0] idx,
  input  logic [RES_W-1:0] value,
  output logic [IDX_W-1:0] max_idx,
  output logic [RES_W-1:0] max_score
);

  logic take;

  // Index 0 always seeds the running max; later ties keep the lower index.
  always_comb begin
    take = (idx == '0) || ($signed(value) > $signed(max_score));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx   <= '0;
      max_score <= '0;
    end else if (clear) begin
      max_idx   <= '0;
      max_score <= '0;
    end else if (update && take) begin
      max_idx   <= idx;
      max_score <= value;
    end
  end

endmodule

// File: rtl/fc_sequencer.sv
// Sequences one fully-connected layer pass over N_OUT neurons through the FC datapath.
// Optional argmax tracking is enabled by defining FC_SEQ_ARGMAX_EN.
module fc_sequencer
  import fc_seq_pkg::*;
#(
  parameter int unsigned N_OUT    = 8,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned WAIT_MAX = 15,
  localparam int unsigned IDX_W   = $clog2(N_OUT)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic             o_mem_en,
  output logic [IDX_W-1:0] o_mem_addr,
  output logic             o_fc_start,
  input  logic             i_fc_finished,
  input  logic [RES_W-1:0] i_fc_output,
  output logic             o_res_valid,
  output logic [IDX_W-1:0] o_res_idx,
  output logic [RES_W-1:0] o_res_data,
  output logic [IDX_W-1:0] o_class,
  output logic [RES_W-1:0] o_class_score
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned WD_W  = $clog2(WAIT_MAX + 1);

  state_e           state;
  logic [IDX_W-1:0] k;
  logic [LAT_W-1:0] lat_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic [RES_W-1:0] res;
  logic             start_accept;

  assign start_accept = (state == S_IDLE) && i_start;
  assign o_mem_addr   = k;
  assign o_res_idx    = k;
  assign o_res_data   = res;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      k           <= '0;
      lat_cnt     <= '0;
      wd_cnt      <= '0;
      res         <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_mem_en    <= 1'b0;
      o_fc_start  <= 1'b0;
      o_res_valid <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_mem_en    <= 1'b0;
      o_fc_start  <= 1'b0;
      o_res_valid <= 1'b0;
      // Abort wins over everything else, including a same-cycle FC finish.
      if (state != S_IDLE && i_abort) begin
        state   <= S_DONE;
        o_error <= 1'b1;
        o_done  <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_accept) begin
              state    <= S_FETCH;
              k        <= '0;
              o_error  <= 1'b0;
              o_busy   <= 1'b1;
              o_mem_en <= 1'b1;
            end
          end
          S_FETCH: begin
            state   <= S_LOAD;
            lat_cnt <= '0;
          end
          S_LOAD: begin
            if (lat_cnt == LAT_W'(MEM_LAT - 1)) begin
              state      <= S_START;
              o_fc_start <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          S_START: begin
            state  <= S_WAIT;
            wd_cnt <= '0;
          end
          S_WAIT: begin
            if (i_fc_finished) begin
              res         <= i_fc_output;
              state       <= S_WRITE;
              o_res_valid <= 1'b1;
            end else if (wd_cnt == WD_W'(WAIT_MAX - 1)) begin
              state   <= S_DONE;
              o_error <= 1'b1;
              o_done  <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          S_WRITE: begin
            if (k == IDX_W'(N_OUT - 1)) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              k        <= k + 1'b1;
              state    <= S_FETCH;
              o_mem_en <= 1'b1;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FC_SEQ_ARGMAX_EN
  fc_seq_argmax #(
    .IDX_W(IDX_W)
  ) u_argmax (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear    (start_accept),
    .update   (o_res_valid),
    .idx      (o_res_idx),
    .value    (o_res_data),
    .max_idx  (o_class),
    .max_score(o_class_score)
  );
`else
  assign o_class       = '0;
  assign o_class_score = '0;
`endif

endmodule

// File: tb/tb_fc_sequencer.sv
// Scoreboard bench for fc_sequencer: a behavioural FC model answers start pulses,
// expected result writes are queued per pass and popped by an independent monitor.
module tb_fc_sequencer;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tb_start = 1'b0;
  logic        start_x = 1'b0;
  logic        i_start;
  logic        i_abort = 1'b0;
  logic        i_fc_finished = 1'b0;
  logic [31:0] i_fc_output = '0;
  logic        o_busy, o_done, o_error, o_mem_en, o_fc_start, o_res_valid;
  logic [2:0]  o_mem_addr, o_res_idx, o_class;
  logic [31:0] o_res_data, o_class_score;

  assign i_start = tb_start | start_x;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;

  exp_t sb[$];
  logic signed [31:0] vals[8];
  int fc_lat = 2;
  int hang_idx = -1;
  int abort_idx = -1;
  bit spur = 1'b0;
  int cd = 0;

  fc_sequencer #(
    .N_OUT(8),
    .MEM_LAT(1),
    .WAIT_MAX(15)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_mem_en     (o_mem_en),
    .o_mem_addr   (o_mem_addr),
    .o_fc_start   (o_fc_start),
    .i_fc_finished(i_fc_finished),
    .i_fc_output  (i_fc_output),
    .o_res_valid  (o_res_valid),
    .o_res_idx    (o_res_idx),
    .o_res_data   (o_res_data),
    .o_class      (o_class),
    .o_class_score(o_class_score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FC model: finished arrives fc_lat cycles after the cycle holding o_fc_start.
  always @(negedge clk) begin
    i_fc_finished = 1'b0;
    i_abort       = 1'b0;
    start_x       = 1'b0;
    if (!rst_n) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0 && int'(o_mem_addr) != hang_idx) begin
          i_fc_finished = 1'b1;
          i_fc_output   = vals[o_mem_addr];
          if (int'(o_mem_addr) == abort_idx) i_abort = 1'b1;
        end
      end
      if (o_fc_start) cd = fc_lat;
      if (spur && o_mem_en && o_mem_addr == 3'd4) begin
        i_fc_finished = 1'b1;
        i_fc_output   = 32'h7fff_ffff;
        start_x       = 1'b1;
      end
    end
  end

  // Monitor: every result strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && o_done) done_cnt++;
    if (rst_n && o_res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_idx", {61'd0, o_res_idx}, 64'hffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_idx", {61'd0, o_res_idx}, {61'd0, e.idx});
        chk("res_data", {32'd0, o_res_data}, {32'd0, e.data});
      end
    end
  end

  task automatic run_pass(input string tag, input int exp_cyc, input int n_wr,
                          input logic exp_err, input logic [2:0] ecls,
                          input logic [31:0] escore);
    int s;
    bit seen;
    exp_t e;
    for (int i = 0; i < n_wr; i++) begin
      e.idx  = 3'(i);
      e.data = vals[i];
      sb.push_back(e);
    end
    @(negedge clk);
    tb_start = 1'b1;
    s = cyc;
    @(negedge clk);
    tb_start = 1'b0;
    chk({tag, "_busy"}, {63'd0, o_busy}, 64'd1);
    chk({tag, "_err_cleared"}, {63'd0, o_error}, 64'd0);
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      if (o_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      chk({tag, "_done_cycle"}, 64'(cyc - s), 64'(exp_cyc));
      chk({tag, "_error"}, {63'd0, o_error}, {63'd0, exp_err});
`ifdef FC_SEQ_ARGMAX_EN
      chk({tag, "_class"}, {61'd0, o_class}, {61'd0, ecls});
      chk({tag, "_score"}, {32'd0, o_class_score}, {32'd0, escore});
`else
      chk({tag, "_class"}, {61'd0, o_class}, 64'd0);
      chk({tag, "_score"}, {32'd0, o_class_score}, 64'd0);
`endif
      @(negedge clk);
      chk({tag, "_done_pulse"}, {63'd0, o_done}, 64'd0);
      chk({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
    end
    chk({tag, "_missing_writes"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    bit seen;
    int dc;
    vals = '{32'sd5, -32'sd3, 32'sd9, 32'sd9, 32'sd0, -32'sd1, 32'sd2, 32'sd7};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {58'd0, o_busy, o_done, o_error, o_mem_en, o_fc_start, o_res_valid},
        64'd0);
    chk("rst_addr_idx_class", {55'd0, o_mem_addr, o_res_idx, o_class}, 64'd0);
    chk("rst_data_score", {o_res_data, o_class_score}, 64'd0);
    rst_n = 1'b1;

    // 8 neurons * (3 + MEM_LAT + L) + 1 = 49 with L=2
    run_pass("normal", 49, 8, 1'b0, 3'd2, 32'd9);

    vals = '{-32'sd8, -32'sd2, -32'sd5, -32'sd7, -32'sd3, -32'sd9, -32'sd4, -32'sd6};
    run_pass("negative", 49, 8, 1'b0, 3'd1, 32'hffff_fffe);

    // Neuron 3 never finishes: 18 + 3 + 15 + 1 = 37
    vals = '{32'sd5, -32'sd3, 32'sd9, 32'sd9, 32'sd0, -32'sd1, 32'sd2, 32'sd7};
    hang_idx = 3;
    run_pass("timeout", 37, 3, 1'b1, 3'd2, 32'd9);
    hang_idx = -1;

    // Abort coincides with finish on neuron 5: 30 + 5 + 1 = 36
    vals = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd100, 32'sd0, 32'sd0};
    abort_idx = 5;
    run_pass("abort", 36, 5, 1'b1, 3'd4, 32'd5);
    abort_idx = -1;

    // Spurious finish + start while busy, L=3: 8 * 7 + 1 = 57
    vals = '{32'sd3, 32'sd3, -32'sd1, 32'sd3, 32'sd2, 32'sd1, 32'sd0, -32'sd5};
    spur = 1'b1;
    fc_lat = 3;
    run_pass("spurious", 57, 8, 1'b0, 3'd0, 32'd3);
    spur = 1'b0;
    fc_lat = 2;

    // Reset while waiting on neuron 1; only neuron 0 reaches the write port.
    vals = '{32'sd5, -32'sd3, 32'sd9, 32'sd9, 32'sd0, -32'sd1, 32'sd2, 32'sd7};
    begin
      exp_t e;
      e.idx  = 3'd0;
      e.data = vals[0];
      sb.push_back(e);
    end
    @(negedge clk);
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (o_fc_start && o_mem_addr == 3'd1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("midreset_reached_wait", {63'd0, seen}, 64'd1);
    @(negedge clk);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midreset_flags", {58'd0, o_busy, o_done, o_error, o_mem_en, o_fc_start, o_res_valid},
        64'd0);
    chk("midreset_addr_idx_class", {55'd0, o_mem_addr, o_res_idx, o_class}, 64'd0);
    chk("midreset_data_score", {o_res_data, o_class_score}, 64'd0);
    chk("midreset_neuron0_written", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("midreset_no_done", 64'(done_cnt - dc), 64'd0);
    rst_n = 1'b1;
    sb.delete();
    run_pass("after_reset", 49, 8, 1'b0, 3'd2, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
